adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 107 ++++++++++
 tb/tb_adder_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 4-bit two's-complement adder.
// Each operation runs IDLE (arbitrate + capture) -> CALC (add) -> DONE (report).
module adder_arbiter #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Req0,
    input  logic [3:0] A0,
    input  logic [3:0] B0,
    input  logic       Req1,
    input  logic [3:0] A1,
    input  logic [3:0] B1,
    output logic       Gnt0,
    output logic       Gnt1,
    output logic       Done0,
    output logic       Done1,
    output logic [3:0] Sum,
    output logic       OverFlow,
    output logic       Busy
);
    localparam int unsigned W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last;
    logic           r_win;
    logic [W-1:0]   r_op_a;
    logic [W-1:0]   r_op_b;

    logic           w_any_req;
    logic           w_pick1;
    logic [W-1:0]   w_sel_a;
    logic [W-1:0]   w_sel_b;
    logic [W-1:0]   w_sum;
    logic           w_ovf;

    // Requester 1 wins when alone, or on a tie when rotating and 0 was served last
    always_comb begin
        w_any_req = Req0 || Req1;
        w_pick1   = Req1 && (!Req0 || ((FIXED_PRIO == 0) && !r_last));
        w_sel_a   = w_pick1 ? A1 : A0;
        w_sel_b   = w_pick1 ? B1 : B0;
        w_sum     = r_op_a + r_op_b;
        w_ovf     = (r_op_a[W-1] == r_op_b[W-1]) && (w_sum[W-1] != r_op_a[W-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            Gnt0     <= 1'b0;
            Gnt1     <= 1'b0;
            Done0    <= 1'b0;
            Done1    <= 1'b0;
            Sum      <= '0;
            OverFlow <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= CALC;
                        r_win   <= w_pick1;
                        r_last  <= w_pick1;
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        Gnt0    <= !w_pick1;
                        Gnt1    <= w_pick1;
                        Busy    <= 1'b1;
                    end
                end
                CALC: begin
                    r_state  <= DONE;
                    Sum      <= w_sum;
                    OverFlow <= w_ovf;
                    Done0    <= !r_win;
                    Done1    <= r_win;
                end
                DONE: begin
                    r_state <= IDLE;
                    Gnt0    <= 1'b0;
                    Gnt1    <= 1'b0;
                    Done0   <= 1'b0;
                    Done1   <= 1'b0;
                    Busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    Gnt0    <= 1'b0;
                    Gnt1    <= 1'b0;
                    Done0   <= 1'b0;
                    Done1   <= 1'b0;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: round-robin and fixed-priority instances side by side,
// checked by a queue-based scoreboard fed from a behavioural arbitration model.
module tb_adder_arbiter;
    logic clk;
    logic rst;

    logic       req0 [2];
    logic [3:0] a0   [2];
    logic [3:0] b0   [2];
    logic       req1 [2];
    logic [3:0] a1   [2];
    logic [3:0] b1   [2];
    logic       gnt0 [2];
    logic       gnt1 [2];
    logic       done0[2];
    logic       done1[2];
    logic [3:0] sum_o[2];
    logic       ovf_o[2];
    logic       busy_o[2];

    // index 0: round-robin, index 1: requester 0 always wins a tie
    adder_arbiter #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .reset(rst),
        .Req0(req0[0]), .A0(a0[0]), .B0(b0[0]),
        .Req1(req1[0]), .A1(a1[0]), .B1(b1[0]),
        .Gnt0(gnt0[0]), .Gnt1(gnt1[0]), .Done0(done0[0]), .Done1(done1[0]),
        .Sum(sum_o[0]), .OverFlow(ovf_o[0]), .Busy(busy_o[0])
    );

    adder_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(rst),
        .Req0(req0[1]), .A0(a0[1]), .B0(b0[1]),
        .Req1(req1[1]), .A1(a1[1]), .B1(b1[1]),
        .Gnt0(gnt0[1]), .Gnt1(gnt1[1]), .Done0(done0[1]), .Done1(done1[1]),
        .Sum(sum_o[1]), .OverFlow(ovf_o[1]), .Busy(busy_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        int         who;
        logic [3:0] sum;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t sb[$];

    int   cyc;
    int   m_busy [2];
    int   m_last [2];
    int   m_win  [2];
    bit   rst_chk[2];

    bit   hold;
    bit   auto_en;
    bit   scramble;
    bit   end_req;

    int   compared;
    int   mismatched;

    // Reference model: adder is free 3 cycles after a grant; ties go to the
    // requester not served last (rotating) or always to 0 (fixed).
    always @(posedge clk) begin
        int   w;
        int   ua;
        int   ub;
        int   t;
        exp_t e;
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            rst_chk[d] = rst;
            if (rst) begin
                m_busy[d] = 0;
                m_last[d] = 1;
                for (int i = sb.size() - 1; i >= 0; i--)
                    if (sb[i].d == d) sb.delete(i);
            end else if (m_busy[d] > 0) begin
                m_busy[d] = m_busy[d] - 1;
            end else if (req0[d] || req1[d]) begin
                if (req0[d] && req1[d])
                    w = (d == 1) ? 0 : ((m_last[d] == 0) ? 1 : 0);
                else
                    w = req1[d] ? 1 : 0;
                m_last[d] = w;
                m_win[d]  = w;
                m_busy[d] = 2;
                ua = (w == 1) ? int'(a1[d]) : int'(a0[d]);
                ub = (w == 1) ? int'(b1[d]) : int'(b0[d]);
                if (ua >= 8) ua = ua - 16;
                if (ub >= 8) ub = ub - 16;
                t     = ua + ub;
                e.d   = d;
                e.who = w;
                e.sum = 4'(t);
                e.ovf = (t > 7) || (t < -8);
                e.due = cyc + 1;
                sb.push_back(e);
            end
        end
    end

    // Monitor: samples just after each rising edge, pops on every Done pulse
    always @(posedge clk) begin
        int         idx;
        exp_t       e;
        logic       eg0;
        logic       eg1;
        logic       eb;
        logic [1:0] ewho;
        bit         any_req;
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst_chk[d]) begin
                compared = compared + 1;
                if (gnt0[d] || gnt1[d] || done0[d] || done1[d] || busy_o[d] ||
                    ovf_o[d] || (sum_o[d] != 4'd0)) begin
                    mismatched = mismatched + 1;
                    $display("FAIL reset_state dut%0d cyc%0d: gnt=%b%b done=%b%b busy=%b sum=%h ovf=%b, need all 0",
                             d, cyc, gnt1[d], gnt0[d], done1[d], done0[d], busy_o[d], sum_o[d], ovf_o[d]);
                end
            end else begin
                eb  = (m_busy[d] != 0);
                eg0 = eb && (m_win[d] == 0);
                eg1 = eb && (m_win[d] == 1);
                compared = compared + 1;
                if ({gnt1[d], gnt0[d], busy_o[d]} != {eg1, eg0, eb}) begin
                    mismatched = mismatched + 1;
                    $display("FAIL grant_busy dut%0d cyc%0d: gnt1/gnt0/busy=%b%b%b, need %b%b%b",
                             d, cyc, gnt1[d], gnt0[d], busy_o[d], eg1, eg0, eb);
                end
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].d == d) idx = i;
                if (done0[d] || done1[d]) begin
                    compared = compared + 1;
                    if (idx < 0) begin
                        mismatched = mismatched + 1;
                        $display("FAIL unexpected_done dut%0d cyc%0d: done1/done0=%b%b, need none",
                                 d, cyc, done1[d], done0[d]);
                    end else begin
                        e = sb[idx];
                        sb.delete(idx);
                        ewho = (e.who == 1) ? 2'b10 : 2'b01;
                        if ({done1[d], done0[d]} != ewho || sum_o[d] != e.sum ||
                            ovf_o[d] != e.ovf || cyc != e.due) begin
                            mismatched = mismatched + 1;
                            $display("FAIL result dut%0d cyc%0d: done1/done0=%b%b sum=%h ovf=%b, need %b sum=%h ovf=%b at cyc%0d",
                                     d, cyc, done1[d], done0[d], sum_o[d], ovf_o[d], ewho, e.sum, e.ovf, e.due);
                        end
                    end
                end else if (idx >= 0 && sb[idx].due <= cyc) begin
                    compared   = compared + 1;
                    mismatched = mismatched + 1;
                    $display("FAIL missing_done dut%0d cyc%0d: no Done, need requester %0d sum=%h",
                             d, cyc, sb[idx].who, sb[idx].sum);
                    sb.delete(idx);
                end
            end
        end
        if (end_req) begin
            any_req = req0[0] || req1[0] || req0[1] || req1[1];
            compared = compared + 1;
            if (sb.size() != 0 || any_req) begin
                mismatched = mismatched + 1;
                $display("FAIL drain: %0d results outstanding, requests high=%b, need 0 and 0",
                         sb.size(), any_req);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
            $finish;
        end
    end

    // One cycle of requester behaviour: drop after own Done, optionally raise/scramble
    task automatic step();
        @(negedge clk);
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (req0[d] && done0[d] && !hold) begin
                    req0[d] = 1'b0;
                end else if (auto_en && !req0[d] && $urandom_range(3) == 0) begin
                    req0[d] = 1'b1;
                    a0[d]   = 4'($urandom);
                    b0[d]   = 4'($urandom);
                end
                if (req1[d] && done1[d] && !hold) begin
                    req1[d] = 1'b0;
                end else if (auto_en && !req1[d] && $urandom_range(3) == 0) begin
                    req1[d] = 1'b1;
                    a1[d]   = 4'($urandom);
                    b1[d]   = 4'($urandom);
                end
                if (scramble) begin
                    if ($urandom_range(1) == 1) a0[d] = 4'($urandom);
                    if ($urandom_range(1) == 1) b0[d] = 4'($urandom);
                    if ($urandom_range(1) == 1) a1[d] = 4'($urandom);
                    if ($urandom_range(1) == 1) b1[d] = 4'($urandom);
                end
            end
        end
    endtask

    task automatic raise0(input logic [3:0] a, input logic [3:0] b);
        for (int d = 0; d < 2; d++) begin
            a0[d] = a; b0[d] = b; req0[d] = 1'b1;
        end
    endtask

    task automatic raise1(input logic [3:0] a, input logic [3:0] b);
        for (int d = 0; d < 2; d++) begin
            a1[d] = a; b1[d] = b; req1[d] = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0; auto_en = 1'b0; scramble = 1'b0; end_req = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req0[d] = 1'b0; a0[d] = 4'd0; b0[d] = 4'd0;
            req1[d] = 1'b0; a1[d] = 4'd0; b1[d] = 4'd0;
        end
        repeat (2) step();
        rst = 1'b0;

        // Basic adds, including positive and negative overflow
        step(); raise0(4'b0011, 4'b0100);
        repeat (6) step();
        raise1(4'b0111, 4'b0001);
        repeat (5) step();
        raise1(4'b1000, 4'b1111);
        repeat (5) step();

        // Both requesters held high straight after reset
        rst = 1'b1; step(); rst = 1'b0;
        hold = 1'b1;
        raise0(4'b0001, 4'b0010);
        raise1(4'b0011, 4'b0100);
        repeat (13) step();
        hold = 1'b0;
        repeat (12) step();

        // Operands change after capture
        raise0(4'b1111, 4'b0001);
        step();
        for (int d = 0; d < 2; d++) a0[d] = 4'b0000;
        repeat (6) step();

        // Reset during CALC with the request still pending
        raise0(4'b0101, 4'b0110);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (8) step();

        // Random traffic with occasional resets
        auto_en = 1'b1; scramble = 1'b1;
        repeat (3000) begin
            step();
            rst = ($urandom_range(199) == 0);
        end
        rst = 1'b0;
        auto_en = 1'b0; scramble = 1'b0;
        repeat (40) step();

        end_req = 1'b1;
        repeat (20) @(negedge clk);
        $display("FAIL watchdog: summary not reached");
        $fatal(1);
    end
endmodule
